// File: rtl/buzzer_pkg.sv
// Shared state encoding and elaboration-time timing helpers for the buzzer tone generator.
package buzzer_pkg;

  typedef enum logic [1:0] {
    BUZZ_IDLE,
    BUZZ_TONE,
    BUZZ_DRAIN
  } buzz_state_t;

  // Clocks per half period of the tone; integer division truncates.
  function automatic int half_period(input int clk_hz, input int tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buzzer_cadence_gen.sv
// On/off cadence window counter; pass_o is the pass/force-low decision for the cycle after the next edge.
// Only instantiated when BUZZER_BEEP_PATTERN_EN is defined; no backpressure, runs every clock while run_i.
module buzzer_cadence_gen
  import buzzer_pkg::*;
#(
  parameter int ON_CYCLES  = 5_000_000,
  parameter int OFF_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic run_i,
  output logic pass_o
);

  localparam int TOTAL = ON_CYCLES + OFF_CYCLES;
  localparam int CW    = cnt_width(TOTAL);
  localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ON_END = CW'(ON_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // A start or an idle tone parks the window at the beginning of ON.
  always_comb begin
    cnt_d = '0;
    if (run_i && !start_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign pass_o = (cnt_d < ON_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/buzzer_tone_generator.sv
// Square-wave piezo driver with minimum tone length and clean period-aligned stop; 1-cycle request latency.
// Optional on/off cadence gating under BUZZER_BEEP_PATTERN_EN; level inputs, no backpressure.
module buzzer_tone_generator
  import buzzer_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int TONE_FREQ_HZ    = 2_000,
  parameter int MIN_PERIODS     = 4,
  parameter int BEEP_ON_CYCLES  = 5_000_000,
  parameter int BEEP_OFF_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic ctrl_en,
  input  logic ctrl_buzz,
  output logic buzzer_out,
  output logic active
);

  localparam int HALF = half_period(CLK_FREQ_HZ, TONE_FREQ_HZ);
  localparam int HCW  = cnt_width(HALF);
  localparam int PCW  = cnt_width(MIN_PERIODS + 1);
  localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF - 1);
  localparam logic [PCW-1:0] PER_MIN   = PCW'(MIN_PERIODS);

  if ((HALF < 1) || (MIN_PERIODS < 1) || (BEEP_ON_CYCLES < 1) || (BEEP_OFF_CYCLES < 1)) begin : g_bad_cfg
    $error("buzzer_tone_generator: HALF, MIN_PERIODS and cadence windows must all be >= 1");
  end

  buzz_state_t    state_q, state_d;
  logic           wave_q, wave_d;
  logic [HCW-1:0] half_cnt_q, half_cnt_d;
  logic [PCW-1:0] period_cnt_q, period_cnt_d;
  logic           out_q, active_q;
  logic           req, wrap, gate_d;

  assign req  = ctrl_en && ctrl_buzz;
  assign wrap = (half_cnt_q == HALF_LAST);

  always_comb begin
    state_d      = state_q;
    wave_d       = wave_q;
    half_cnt_d   = half_cnt_q;
    period_cnt_d = period_cnt_q;
    case (state_q)
      BUZZ_IDLE: begin
        if (req) begin
          state_d = BUZZ_TONE;
          wave_d  = 1'b1;
        end
      end
      BUZZ_TONE, BUZZ_DRAIN: begin
        if (wrap) begin
          half_cnt_d = '0;
          wave_d     = !wave_q;
          if (wave_q && (period_cnt_q != PER_MIN)) begin
            period_cnt_d = period_cnt_q + 1'b1;
          end
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
        // A release that lands on a half wrap stops right there: a 1->0 wrap closes the last
        // period, and a 0->1 wrap must not start a fresh high half.
        if (req) begin
          state_d = BUZZ_TONE;
        end else if ((state_q == BUZZ_DRAIN) || (period_cnt_d >= PER_MIN)) begin
          state_d = wrap ? BUZZ_IDLE : BUZZ_DRAIN;
        end
      end
      default: state_d = BUZZ_IDLE;
    endcase
    if (!ctrl_en) begin
      state_d = BUZZ_IDLE;
    end
    if (state_d == BUZZ_IDLE) begin
      wave_d       = 1'b0;
      half_cnt_d   = '0;
      period_cnt_d = '0;
    end
  end

`ifdef BUZZER_BEEP_PATTERN_EN
  buzzer_cadence_gen #(
    .ON_CYCLES  (BEEP_ON_CYCLES),
    .OFF_CYCLES (BEEP_OFF_CYCLES)
  ) u_cadence (
    .clk     (clk),
    .rst     (rst),
    .start_i ((state_q == BUZZ_IDLE) && (state_d == BUZZ_TONE)),
    .run_i   (state_d != BUZZ_IDLE),
    .pass_o  (gate_d)
  );
`else
  assign gate_d = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BUZZ_IDLE;
      wave_q       <= 1'b0;
      half_cnt_q   <= '0;
      period_cnt_q <= '0;
      out_q        <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wave_q       <= wave_d;
      half_cnt_q   <= half_cnt_d;
      period_cnt_q <= period_cnt_d;
      out_q        <= wave_d && gate_d;
      active_q     <= (state_d != BUZZ_IDLE);
    end
  end

  assign buzzer_out = out_q;
  assign active     = active_q;

endmodule

// File: tb/tb_buzzer_tone_generator.sv
// Table-driven bench for buzzer_tone_generator (HALF=5, MIN_PERIODS=2); expectations flow through a scoreboard queue.
module tb_buzzer_tone_generator;

  localparam int CLK_HZ   = 1000;
  localparam int TONE_HZ  = 100;
  localparam int MIN_P    = 2;
  localparam int BEEP_ON  = 20;
  localparam int BEEP_OFF = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ctrl_en = 1'b0;
  logic ctrl_buzz = 1'b0;
  logic buzzer_out;
  logic active;

  buzzer_tone_generator #(
    .CLK_FREQ_HZ     (CLK_HZ),
    .TONE_FREQ_HZ    (TONE_HZ),
    .MIN_PERIODS     (MIN_P),
    .BEEP_ON_CYCLES  (BEEP_ON),
    .BEEP_OFF_CYCLES (BEEP_OFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_en    (ctrl_en),
    .ctrl_buzz  (ctrl_buzz),
    .buzzer_out (buzzer_out),
    .active     (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    n;
    logic  rst;
    logic  en;
    logic  buzz;
    logic  exp_out;
    logic  exp_act;
    string tag;
  } vec_t;

  typedef struct {
    logic  exp_out;
    logic  exp_act;
    string tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // f = {rst, en, buzz, exp_out, exp_act}; held for n consecutive edges.
  function automatic void add(input int n, input bit [4:0] f, input string tag);
    vec_t v;
    v = '{n, f[4], f[3], f[2], f[1], f[0], tag};
    vecs.push_back(v);
  endfunction

  task automatic step(input vec_t v);
    exp_t e;
    rst       = v.rst;
    ctrl_en   = v.en;
    ctrl_buzz = v.buzz;
    e = '{v.exp_out, v.exp_act, v.tag};
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (buzzer_out !== e.exp_out) begin
          failures++;
          $display("FAIL %s buzzer_out got=%b want=%b t=%0t", e.tag, buzzer_out, e.exp_out, $time);
        end
        checks++;
        if (active !== e.exp_act) begin
          failures++;
          $display("FAIL %s active got=%b want=%b t=%0t", e.tag, active, e.exp_act, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    add(2, 5'b1_11_00, "reset");
`ifdef BUZZER_BEEP_PATTERN_EN
    add(5,  5'b0_11_11, "cad_hi1");
    add(5,  5'b0_11_01, "cad_lo1");
    add(5,  5'b0_11_11, "cad_hi2");
    add(5,  5'b0_11_01, "cad_lo2");
    add(20, 5'b0_11_01, "cad_off1");
    add(5,  5'b0_11_11, "cad_on2_hi1");
    add(5,  5'b0_11_01, "cad_on2_lo1");
    add(5,  5'b0_11_11, "cad_on2_hi2");
    add(5,  5'b0_11_01, "cad_on2_lo2");
    add(2,  5'b0_11_01, "cad_off2");
    add(3,  5'b0_10_01, "cad_off_drain");
    add(3,  5'b0_10_00, "cad_idle");
    add(5,  5'b0_11_11, "cad_restart_hi");
    add(5,  5'b0_11_01, "cad_restart_lo");
    add(1,  5'b0_01_00, "cad_mute");
`else
    // continuous tone, then release 2 clocks into the 4th high half
    add(5, 5'b0_11_11, "cont_hi1");
    add(5, 5'b0_11_01, "cont_lo1");
    add(5, 5'b0_11_11, "cont_hi2");
    add(5, 5'b0_11_01, "cont_lo2");
    add(5, 5'b0_11_11, "cont_hi3");
    add(5, 5'b0_11_01, "cont_lo3");
    add(2, 5'b0_11_11, "late_hi4");
    add(3, 5'b0_10_11, "late_drain");
    add(4, 5'b0_10_00, "late_idle");
    // one-cycle pulse stretched to MIN_PERIODS
    add(1, 5'b0_11_11, "pulse_start");
    add(4, 5'b0_10_11, "pulse_hi1");
    add(5, 5'b0_10_01, "pulse_lo1");
    add(5, 5'b0_10_11, "pulse_hi2");
    add(5, 5'b0_10_00, "pulse_done");
    // release inside a low half: no extra high half
    add(5, 5'b0_11_11, "ld_hi1");
    add(5, 5'b0_11_01, "ld_lo1");
    add(5, 5'b0_11_11, "ld_hi2");
    add(2, 5'b0_11_01, "ld_lo2");
    add(3, 5'b0_10_01, "ld_drain");
    add(3, 5'b0_10_00, "ld_idle");
    // request returns during drain, phase kept
    add(5, 5'b0_11_11, "ra_hi1");
    add(5, 5'b0_11_01, "ra_lo1");
    add(5, 5'b0_11_11, "ra_hi2");
    add(5, 5'b0_11_01, "ra_lo2");
    add(2, 5'b0_11_11, "ra_hi3");
    add(2, 5'b0_10_11, "ra_drain");
    add(1, 5'b0_11_11, "ra_back");
    add(5, 5'b0_11_01, "ra_lo3");
    add(2, 5'b0_11_11, "ra_hi4");
    add(1, 5'b0_01_00, "ra_mute");
    // enable drop overrides the minimum stretch
    add(1, 5'b0_11_11, "ms_start");
    add(2, 5'b0_10_11, "ms_hi");
    add(2, 5'b0_00_00, "ms_mute");
    // mute mid high half, restart with a full high half, then reset mid tone
    add(2, 5'b0_11_11, "m5_hi");
    add(1, 5'b0_01_00, "m5_mute");
    add(5, 5'b0_11_11, "m5_rehi");
    add(5, 5'b0_11_01, "m5_relo");
    add(2, 5'b0_11_11, "m5_hi2");
    add(1, 5'b1_11_00, "rst_mid");
    add(2, 5'b0_00_00, "final_idle");
`endif
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        step(vecs[i]);
      end
    end
    #10;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
